// File: rtl/micro_sequencer.sv
// Microcode sequencer: writable control store, programmable family dispatch,
// micro-call return stack and a sticky halt state.
module micro_sequencer #(
    parameter int UADDR_W     = 7,
    parameter int CW_W        = 64,
    parameter int FETCH_ADDR  = 104,
    parameter int STACK_DEPTH = 4,
    parameter int FAMILY_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FAMILY_W-1:0] family,
    input  logic                cond,
    input  logic                st,
    input  logic                pl,
    input  logic                a,
    input  logic                mem_ready,
    input  logic                stall,
    input  logic                cs_we,
    input  logic [UADDR_W-1:0]  cs_waddr,
    input  logic [CW_W-1:0]     cs_wdata,
    input  logic                dm_we,
    input  logic [FAMILY_W-1:0] dm_waddr,
    input  logic [UADDR_W-1:0]  dm_wdata,
    output logic [CW_W-1:0]     cs_bits,
    output logic [UADDR_W-1:0]  uaddr,
    output logic                halted,
    output logic                stack_err
);

    localparam int DEPTH = 1 << UADDR_W;
    localparam int NFAM  = 1 << FAMILY_W;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [UADDR_W-1:0] FETCH = UADDR_W'(FETCH_ADDR);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    // Power-on dispatch table; the remapped entries only exist for 4-bit families.
    function automatic logic [UADDR_W-1:0] dm_reset_val(input int f);
        int v;
        v = f;
        if (FAMILY_W == 4) begin
            case (f)
                5, 6, 7, 15:   v = 14;
                8, 9, 10, 11:  v = 5;
                12:            v = 8;
                13:            v = 9;
                14:            v = 7;
                default:       v = f;
            endcase
        end
        return UADDR_W'(v << 3);
    endfunction

    logic [CW_W-1:0]     cs_mem [DEPTH];
    logic [UADDR_W-1:0]  dm_reg [NFAM];
    logic [UADDR_W-1:0]  stack_reg [STACK_DEPTH];

    state_t              state_reg, state_next;
    logic [UADDR_W-1:0]  uaddr_reg, uaddr_next;
    logic [SP_W-1:0]     sp_reg, sp_next;
    logic                stack_err_reg, stack_err_next;
    logic                push_en;
    logic [IDX_W-1:0]    push_idx, pop_idx;

    logic [UADDR_W-1:0]  j_field, jump_target;
    logic [1:0]          mod_field, seq_field;
    logic                evcond, memwait;

    assign cs_bits   = cs_mem[uaddr_reg];
    assign uaddr     = uaddr_reg;
    assign halted    = (state_reg == ST_HALT);
    assign stack_err = stack_err_reg;

    assign j_field   = cs_bits[CW_W-1 -: UADDR_W];
    assign mod_field = cs_bits[CW_W-UADDR_W-1 -: 2];
    assign seq_field = cs_bits[CW_W-UADDR_W-3 -: 2];
    assign evcond    = cs_bits[CW_W-UADDR_W-5];
    assign memwait   = cs_bits[CW_W-UADDR_W-6];

    assign push_idx  = IDX_W'(sp_reg);
    assign pop_idx   = IDX_W'(sp_reg - SP_W'(1));

    always_comb begin
        jump_target = j_field;
        case (mod_field)
            2'b11:   jump_target[2] = j_field[2] | st;
            2'b10:   jump_target[1] = j_field[1] | pl;
            2'b01:   jump_target[0] = j_field[0] | a;
            default: jump_target    = j_field;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        uaddr_next     = uaddr_reg;
        sp_next        = sp_reg;
        stack_err_next = stack_err_reg;
        push_en        = 1'b0;
        if (state_reg == ST_HALT || stall || (memwait && !mem_ready)) begin
            uaddr_next = uaddr_reg;
        end else if (evcond && !cond) begin
            uaddr_next = FETCH;
        end else begin
            case (seq_field)
                2'b00: uaddr_next = jump_target;
                2'b01: begin
                    // An unprogrammed top family is treated as an illegal opcode.
                    if (family == FAMILY_W'(NFAM - 1) && dm_reg[NFAM-1] == dm_reset_val(NFAM - 1))
                        state_next = ST_HALT;
                    else
                        uaddr_next = dm_reg[family];
                end
                2'b10: begin
                    if (sp_reg == SP_W'(STACK_DEPTH)) begin
                        stack_err_next = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_next = sp_reg + SP_W'(1);
                    end
                    uaddr_next = jump_target;
                end
                default: begin
                    if (sp_reg == '0) begin
                        uaddr_next     = FETCH;
                        stack_err_next = 1'b1;
                    end else begin
                        uaddr_next = stack_reg[pop_idx];
                        sp_next    = sp_reg - SP_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            uaddr_reg     <= FETCH;
            sp_reg        <= '0;
            stack_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            uaddr_reg     <= uaddr_next;
            sp_reg        <= sp_next;
            stack_err_reg <= stack_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !rst)
            stack_reg[push_idx] <= uaddr_reg + UADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (cs_we)
            cs_mem[cs_waddr] <= cs_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NFAM; i++)
                dm_reg[i] <= dm_reset_val(i);
        end else if (dm_we) begin
            dm_reg[dm_waddr] <= dm_wdata;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: expectations queued per step and checked
// with immediate assertions one time unit after each rising edge.
module tb_micro_sequencer;

    localparam int SEL_UA = 0, SEL_HALT = 1, SEL_ERR = 2, SEL_CS = 3;
    localparam int JMP = 0, DEC = 1, CALL = 2, RET = 3;

    logic        clk = 1'b0;
    logic        rst, cond, st, pl, a, mem_ready, stall, cs_we, dm_we;
    logic [3:0]  family, dm_waddr;
    logic [6:0]  cs_waddr, dm_wdata, uaddr;
    logic [63:0] cs_wdata, cs_bits;
    logic        halted, stack_err;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    micro_sequencer dut (
        .clk(clk), .rst(rst), .family(family), .cond(cond), .st(st), .pl(pl), .a(a),
        .mem_ready(mem_ready), .stall(stall), .cs_we(cs_we), .cs_waddr(cs_waddr),
        .cs_wdata(cs_wdata), .dm_we(dm_we), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata),
        .cs_bits(cs_bits), .uaddr(uaddr), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cw(input int j, input int md, input int sq,
                                       input bit ev, input bit mw);
        return {7'(j), 2'(md), 2'(sq), ev, mw, 51'd0};
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [63:0] obs;
        @(posedge clk);
        #1;
        $display("[TB] t=%0t uaddr=%0d halted=%0b stack_err=%0b", $time, uaddr, halted, stack_err);
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                SEL_UA:   obs = {57'd0, uaddr};
                SEL_HALT: obs = {63'd0, halted};
                SEL_ERR:  obs = {63'd0, stack_err};
                default:  obs = cs_bits;
            endcase
            tests++;
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Rewrite the word at the current address while frozen; it shows up on cs_bits next cycle.
    task automatic rewrite(input int addr, input logic [63:0] w);
        stall    = 1'b1;
        cs_we    = 1'b1;
        cs_waddr = 7'(addr);
        cs_wdata = w;
        expect_val("stall_hold", SEL_UA, 64'(addr));
        expect_val("cs_write_visible", SEL_CS, w);
        tick();
        cs_we = 1'b0;
        stall = 1'b0;
    endtask

    task automatic step(input string tag, input int exp_ua);
        expect_val(tag, SEL_UA, 64'(exp_ua));
        tick();
    endtask

    initial begin
        int ret_addr[4];
        rst = 1'b1; cond = 1'b1; st = 1'b0; pl = 1'b0; a = 1'b0; mem_ready = 1'b1;
        stall = 1'b0; cs_we = 1'b0; dm_we = 1'b0; family = 4'd0; dm_waddr = 4'd0;
        cs_waddr = 7'd0; dm_wdata = 7'd0; cs_wdata = 64'd0;

        // Reset for two cycles while loading the fetch word and word 0.
        cs_we = 1'b1; cs_waddr = 7'd104; cs_wdata = cw(0, 0, JMP, 0, 0);
        tick();
        cs_waddr = 7'd0; cs_wdata = cw(104, 0, JMP, 0, 0);
        expect_val("reset_uaddr", SEL_UA, 64'd104);
        expect_val("reset_halted", SEL_HALT, 64'd0);
        expect_val("reset_stack_err", SEL_ERR, 64'd0);
        expect_val("reset_cs_bits", SEL_CS, cw(0, 0, JMP, 0, 0));
        tick();
        rst = 1'b0; cs_we = 1'b0;
        step("fetch_jump_0", 0);
        step("jump_back_104", 104);

        // Decode with memory wait.
        rewrite(104, cw(0, 0, DEC, 0, 1));
        family = 4'd9; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("memwait_hold", 104);
        mem_ready = 1'b1;
        step("decode_family9", 40);

        // Jump target modifiers.
        rewrite(40, cw(10, 0, JMP, 0, 0));
        step("plain_jump", 10);
        rewrite(10, cw(16, 3, JMP, 0, 0));
        st = 1'b1;
        step("mod11_st", 20);
        st = 1'b0;
        rewrite(20, cw(16, 2, JMP, 0, 0));
        pl = 1'b1;
        step("mod10_pl", 18);
        pl = 1'b0;
        rewrite(18, cw(16, 1, JMP, 0, 0));
        a = 1'b1;
        step("mod01_a", 17);
        a = 1'b0;
        rewrite(17, cw(16, 3, JMP, 0, 0));
        step("mod11_st0", 16);
        rewrite(16, cw(10, 0, JMP, 0, 0));
        step("back_to_10", 10);
        rewrite(10, cw(16, 3, JMP, 1, 0));
        st = 1'b1; stall = 1'b1;
        step("stall_hold_10", 10);
        stall = 1'b0; cond = 1'b0;
        step("evcond_abort", 104);
        cond = 1'b1; st = 1'b0;

        // Call / return, then overflow past four entries.
        rewrite(104, cw(10, 0, JMP, 0, 0));
        step("to_10", 10);
        rewrite(10, cw(50, 0, CALL, 0, 0));
        step("call_50", 50);
        rewrite(50, cw(0, 0, RET, 0, 0));
        step("return_11", 11);
        rewrite(11, cw(20, 0, CALL, 0, 0));
        step("call1", 20);
        rewrite(20, cw(30, 0, CALL, 0, 0));
        step("call2", 30);
        rewrite(30, cw(40, 0, CALL, 0, 0));
        step("call3", 40);
        rewrite(40, cw(60, 0, CALL, 0, 0));
        expect_val("no_err_at_depth", SEL_ERR, 64'd0);
        step("call4", 60);
        rewrite(60, cw(70, 0, CALL, 0, 0));
        expect_val("overflow_err", SEL_ERR, 64'd1);
        step("call5_taken", 70);
        ret_addr = '{41, 31, 21, 12};
        rewrite(70, cw(0, 0, RET, 0, 0));
        step("pop_lifo", ret_addr[0]);
        for (int i = 1; i < 4; i++) begin
            rewrite(ret_addr[i-1], cw(0, 0, RET, 0, 0));
            step("pop_lifo", ret_addr[i]);
        end

        // Underflow from a clean reset.
        rst = 1'b1;
        tick();
        cs_we = 1'b1; cs_waddr = 7'd104; cs_wdata = cw(0, 0, RET, 0, 0);
        expect_val("rst2_uaddr", SEL_UA, 64'd104);
        expect_val("rst2_err_clear", SEL_ERR, 64'd0);
        tick();
        rst = 1'b0; cs_we = 1'b0;
        expect_val("underflow_err", SEL_ERR, 64'd1);
        step("underflow_fetch", 104);

        // Programmed dispatch entry.
        dm_we = 1'b1; dm_waddr = 4'd3; dm_wdata = 7'd96;
        rewrite(104, cw(0, 0, DEC, 0, 0));
        dm_we = 1'b0; family = 4'd3;
        step("dispatch_written", 96);

        // Call from the top address wraps the return address to 0.
        rewrite(96, cw(127, 0, JMP, 0, 0));
        step("to_127", 127);
        rewrite(127, cw(5, 0, CALL, 0, 0));
        step("call_from_127", 5);
        rewrite(5, cw(0, 0, RET, 0, 0));
        step("return_wraps_0", 0);

        // Unprogrammed family 15 halts until reset.
        rewrite(0, cw(0, 0, DEC, 0, 0));
        family = 4'd15;
        expect_val("halt_set", SEL_HALT, 64'd1);
        step("halt_uaddr", 0);
        rewrite(0, cw(33, 0, JMP, 0, 0));
        expect_val("halt_sticky", SEL_HALT, 64'd1);
        step("halt_frozen", 0);
        rst = 1'b1;
        expect_val("halt_cleared", SEL_HALT, 64'd0);
        step("halt_reset_uaddr", 104);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
